rk_kbd_matrix: RTL and testbench
================================

RK_KBD_MATRIX -- requirements
Module: rk_kbd_matrix

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ROWS, 8, matrix rows (1..16).
  COLS, 8, matrix columns (1..8).
  NMOD, 3, modifier outputs (1..4).
  ACTIVE_LOW, 0, 1 = odata bits read 0 for pressed keys.
  MAP_FILE, "rk_kbd_map.hex", map RAM initial contents.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; one clock, all logic on rising edge.
  reset  in  1  synchronous, active-high.
  code_valid  in  1  one-cycle strobe, byte from PS/2 receiver.
  code  in  8  received scan-code byte.
  map_we  in  1  map RAM write enable.
  map_addr  in  9  map index {ext, code}.
  map_wdata  in  2+4+3  map entry {kind[1:0], row[3:0], col[2:0]}.
  addr  in  ROWS  row select, active-high, several rows allowed.
  odata  out  COLS  OR of selected rows (inverted if ACTIVE_LOW).
  shift  out  NMOD  modifier levels, 1 = held.
  k_reset  out  1  system-reset key held.

Function
REQ-003 The map RAM SHALL be 512 x 9: index 0..255 plain codes, 256..511 E0-prefixed codes.
REQ-004 kind SHALL be 00 = ignore, 01 = matrix key at (row,col), 10 = modifier with index col, 11 = system-reset key.
REQ-005 The prefix FSM SHALL have states IDLE, EXT, BRK, EXT_BRK and SKIP; it advances only on code_valid.
REQ-006 Transitions: E0 in IDLE -> EXT; F0 in IDLE -> BRK; F0 in EXT -> EXT_BRK; E1 in IDLE -> SKIP with count 7; in SKIP, each byte decrements the count and the FSM returns to IDLE at 0.
REQ-007 Any other byte in IDLE/EXT/BRK/EXT_BRK SHALL issue a lookup at {ext, code} with make = not break, then return to IDLE.
REQ-008 An E0 or E1 arriving in EXT, BRK or EXT_BRK SHALL return the FSM to IDLE without a lookup, then be reprocessed as a new prefix.
REQ-009 AA, 00 or FF arriving in IDLE SHALL clear the matrix, shift and k_reset on the next edge, with no lookup.
REQ-010 Latency: final byte strobed in cycle N -> registered RAM read in N+1 -> matrix/shift/k_reset updated at the end of N+1, visible in N+2.
REQ-011 kind 01 make SHALL set bit [row][col] and break SHALL clear it; repeated makes (typematic) leave state unchanged.
REQ-012 Entries with row >= ROWS or col >= COLS SHALL be ignored, as SHALL kind 10 with col >= NMOD.
REQ-013 kind 10 SHALL set or clear shift[col]; kind 11 SHALL drive k_reset high on make and low on break.
REQ-014 odata SHALL be combinational: OR over r of (matrix[r] & {COLS{addr[r]}}), and 0 when addr = 0 (all ones if ACTIVE_LOW).
REQ-015 A map write and a lookup in the same cycle SHALL both complete; the lookup returns old data when addresses match (read-first).
REQ-016 The block SHALL accept a code_valid every cycle with no backpressure; back-to-back lookups SHALL pipeline without loss.

Reset
REQ-017 reset SHALL clear the matrix, shift and k_reset to 0, set the FSM to IDLE, set the SKIP count to 0 and discard the in-flight lookup.
REQ-018 reset SHALL NOT alter map RAM contents; a reset mid-prefix SHALL treat the next byte as fresh.

Structure
REQ-019 Package rk_kbd_pkg SHALL hold the kind encodings, the prefix constants (E0, E1, F0, AA, 00, FF), the E1 skip length and the map field widths.
REQ-020 Sub-module rk_kbd_prefix SHALL contain the prefix FSM and emit lookup_valid, lookup_addr[8:0], lookup_make and clear_all.

Verification
REQ-021 Directed scenarios:
  1C then F0 1C, map[0x01C] = {01,4,1}, addr = 0x10 -> odata = 0x02 two cycles after 1C, then 0x00 after 1C following F0.
  E0 75 vs 75 with map[0x175] = {01,2,3} and map[0x075] = {00,..} -> only E0 75 sets bit [2][3].
  E1 14 77 E1 F0 14 F0 77 then 1C -> no change during the sequence, 1C sets its key.
  12 (map {10,0,0}) held, then AA -> shift[0] = 1, then all outputs 0 after AA.
  Keys at rows 0 and 3 held, addr = 0x09 -> odata = OR of both rows; addr = 0 -> 0x00; with ACTIVE_LOW = 1 -> inverted.
  F0 followed by reset, then 1C -> 1C treated as make; map write to 0x01C in the same cycle as a 1C lookup -> old entry used.

Source files
------------

// File: rtl/rk_kbd_pkg.sv
// Shared encodings for the PS/2 scan-code to key-matrix translator:
// map entry layout, entry kinds, prefix bytes and the prefix FSM states.
package rk_kbd_pkg;

  localparam int KIND_W     = 2;
  localparam int ROW_W      = 4;
  localparam int COL_W      = 3;
  localparam int ENTRY_W    = KIND_W + ROW_W + COL_W;
  localparam int MAP_ADDR_W = 9;
  localparam int MAP_DEPTH  = 1 << MAP_ADDR_W;

  typedef enum logic [KIND_W-1:0] {
    KIND_IGNORE = 2'b00,
    KIND_KEY    = 2'b01,
    KIND_MOD    = 2'b10,
    KIND_RESET  = 2'b11
  } kind_e;

  typedef struct packed {
    kind_e            kind;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } map_entry_t;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_AA = 8'hAA;
  localparam logic [7:0] CODE_00 = 8'h00;
  localparam logic [7:0] CODE_FF = 8'hFF;

  // Pause/Break sends E1 followed by seven bytes that carry no key state.
  localparam int               SKIP_W      = 3;
  localparam logic [SKIP_W-1:0] E1_SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } prefix_state_e;

  function automatic logic is_clear_code(input logic [7:0] c);
    return (c == CODE_AA) || (c == CODE_00) || (c == CODE_FF);
  endfunction

endpackage

// File: rtl/rk_kbd_prefix.sv
// Scan-code prefix decoder: folds E0/F0/E1 prefixes into a single map lookup
// request, and flags the keyboard self-test/error bytes that wipe all key state.
module rk_kbd_prefix
  import rk_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic       lookup_valid,
  output logic [8:0] lookup_addr,
  output logic       lookup_make,
  output logic       clear_all
);

  prefix_state_e     state, state_next;
  logic [SKIP_W-1:0] skip_cnt, skip_next;
  logic              ext, brk;

  assign ext = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign brk = (state == ST_BRK) || (state == ST_EXT_BRK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  // E0/E1 seen mid-prefix abandon the old prefix and start a new one,
  // so they are handled identically in every non-SKIP state.
  always_comb begin
    state_next   = state;
    skip_next    = skip_cnt;
    lookup_valid = 1'b0;
    lookup_addr  = {ext, code};
    lookup_make  = !brk;
    clear_all    = 1'b0;
    if (code_valid) begin
      case (state)
        ST_SKIP: begin
          skip_next = skip_cnt - 1'b1;
          if (skip_next == '0) state_next = ST_IDLE;
        end
        default: begin
          if (code == CODE_E0) begin
            state_next = ST_EXT;
          end else if (code == CODE_E1) begin
            state_next = ST_SKIP;
            skip_next  = E1_SKIP_LEN;
          end else if (code == CODE_F0 && state == ST_IDLE) begin
            state_next = ST_BRK;
          end else if (code == CODE_F0 && state == ST_EXT) begin
            state_next = ST_EXT_BRK;
          end else if (state == ST_IDLE && is_clear_code(code)) begin
            clear_all  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            lookup_valid = 1'b1;
            state_next   = ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/rk_kbd_matrix.sv
// PS/2 keyboard to emulated key-matrix bridge: scan codes are translated through
// a writable 512-entry map into matrix bits, modifier levels and a reset key.
module rk_kbd_matrix
  import rk_kbd_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int NMOD       = 3,
  parameter bit ACTIVE_LOW = 1'b0,
  // Consumed only by FPGA init flows; in this RTL the map is loaded via map_we.
  parameter     MAP_FILE   = "rk_kbd_map.hex"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            code_valid,
  input  logic [7:0]      code,
  input  logic            map_we,
  input  logic [8:0]      map_addr,
  input  logic [8:0]      map_wdata,
  input  logic [ROWS-1:0] addr,
  output logic [COLS-1:0] odata,
  output logic [NMOD-1:0] shift,
  output logic            k_reset
);

  logic       lookup_valid, lookup_make, clear_all;
  logic [8:0] lookup_addr;

  rk_kbd_prefix u_prefix (
    .clk          (clk),
    .reset        (reset),
    .code_valid   (code_valid),
    .code         (code),
    .lookup_valid (lookup_valid),
    .lookup_addr  (lookup_addr),
    .lookup_make  (lookup_make),
    .clear_all    (clear_all)
  );

  logic [ENTRY_W-1:0] map_mem [MAP_DEPTH];
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid, rd_make;
  map_entry_t         rd_entry;

  // Read-first RAM: a same-cycle write to the looked-up index is not seen by that lookup.
  always_ff @(posedge clk) begin
    if (map_we) map_mem[map_addr] <= map_wdata;
    rd_data <= map_mem[lookup_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_make  <= 1'b0;
    end else begin
      rd_valid <= lookup_valid;
      rd_make  <= lookup_make;
    end
  end

  assign rd_entry = map_entry_t'(rd_data);

  logic [COLS-1:0] matrix [ROWS];

  // Out-of-range rows/cols/modifier indices simply match no loop iteration.
  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      for (int r = 0; r < ROWS; r++) matrix[r] <= '0;
      shift   <= '0;
      k_reset <= 1'b0;
    end else if (rd_valid) begin
      case (rd_entry.kind)
        KIND_KEY: begin
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              if (rd_entry.row == ROW_W'(r) && rd_entry.col == COL_W'(c))
                matrix[r][c] <= rd_make;
        end
        KIND_MOD: begin
          for (int m = 0; m < NMOD; m++)
            if (rd_entry.col == COL_W'(m)) shift[m] <= rd_make;
        end
        KIND_RESET: k_reset <= rd_make;
        default: ;
      endcase
    end
  end

  logic [COLS-1:0] row_or;

  always_comb begin
    row_or = '0;
    for (int r = 0; r < ROWS; r++)
      if (addr[r]) row_or = row_or | matrix[r];
  end

  assign odata = ACTIVE_LOW ? ~row_or : row_or;

endmodule

// File: tb/tb_rk_kbd_matrix.sv
// Directed bench for rk_kbd_matrix: a byte-per-record vector table plus hand-written
// sequences for latency, back-to-back strobes, reset mid-prefix and read-first RAM.
module tb_rk_kbd_matrix;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] code;
  logic       map_we;
  logic [8:0] map_addr;
  logic [8:0] map_wdata;
  logic [7:0] addr;
  logic [7:0] odata, odata_al;
  logic [2:0] shift, shift_al;
  logic       k_reset, k_reset_al;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rk_kbd_matrix #(.ROWS(8), .COLS(8), .NMOD(3), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code),
    .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
    .addr(addr), .odata(odata), .shift(shift), .k_reset(k_reset)
  );

  rk_kbd_matrix #(.ROWS(8), .COLS(8), .NMOD(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code),
    .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
    .addr(addr), .odata(odata_al), .shift(shift_al), .k_reset(k_reset_al)
  );

  typedef struct {
    logic [7:0] code;
    logic [7:0] addr;
    logic [7:0] odata;
    logic [2:0] shift;
    logic       krst;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] entry(input logic [1:0] kind, input logic [3:0] row,
                                       input logic [2:0] col);
    return {kind, row, col};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_map(input logic [8:0] a, input logic [8:0] d);
    map_we    = 1'b1;
    map_addr  = a;
    map_wdata = d;
    tick();
    map_we    = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    code_valid = 1'b1;
    code       = b;
    tick();
    code_valid = 1'b0;
  endtask

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] a, input logic [7:0] exp_o,
                             input logic [2:0] exp_s, input logic exp_k);
    addr = a;
    #1;
    compare({name, ".odata"},    odata,             exp_o);
    compare({name, ".odata_al"}, odata_al,          ~exp_o);
    compare({name, ".shift"},    {5'b0, shift},     {5'b0, exp_s});
    compare({name, ".k_reset"},  {7'b0, k_reset},   {7'b0, exp_k});
  endtask

  task automatic add_vec(input logic [7:0] c, input logic [7:0] a, input logic [7:0] o,
                         input logic [2:0] s, input logic k);
    vecs.push_back('{code: c, addr: a, odata: o, shift: s, krst: k});
  endtask

  initial begin
    reset      = 1'b1;
    code_valid = 1'b0;
    code       = 8'h00;
    map_we     = 1'b0;
    map_addr   = '0;
    map_wdata  = '0;
    addr       = 8'h00;

    tick();
    tick();
    checkOutput("reset_state", 8'hFF, 8'h00, 3'b000, 1'b0);

    for (int i = 0; i < 512; i++) write_map(9'(i), 9'h000);
    write_map(9'h01C, entry(2'b01, 4'd4, 3'd1));
    write_map(9'h175, entry(2'b01, 4'd2, 3'd3));
    write_map(9'h012, entry(2'b10, 4'd0, 3'd0));
    write_map(9'h014, entry(2'b10, 4'd0, 3'd1));
    write_map(9'h077, entry(2'b01, 4'd7, 3'd7));
    write_map(9'h076, entry(2'b11, 4'd0, 3'd0));
    write_map(9'h015, entry(2'b01, 4'd0, 3'd0));
    write_map(9'h01D, entry(2'b01, 4'd3, 3'd5));
    write_map(9'h016, entry(2'b01, 4'd9, 3'd0));
    write_map(9'h01E, entry(2'b10, 4'd0, 3'd3));
    write_map(9'h0AA, entry(2'b01, 4'd6, 3'd6));
    write_map(9'h000, entry(2'b01, 4'd6, 3'd7));
    write_map(9'h0FF, entry(2'b01, 4'd5, 3'd7));
    write_map(9'h0F0, entry(2'b01, 4'd7, 3'd0));
    write_map(9'h0E0, entry(2'b01, 4'd7, 3'd1));
    write_map(9'h0E1, entry(2'b01, 4'd7, 3'd2));
    write_map(9'h1E0, entry(2'b01, 4'd7, 3'd3));
    write_map(9'h1E1, entry(2'b01, 4'd7, 3'd4));
    reset = 1'b0;
    tick();

    //        code   addr   odata  shift   krst
    add_vec(8'h1C, 8'h10, 8'h02, 3'b000, 1'b0);
    add_vec(8'hF0, 8'h10, 8'h02, 3'b000, 1'b0);
    add_vec(8'h1C, 8'h10, 8'h00, 3'b000, 1'b0);
    add_vec(8'h75, 8'h04, 8'h00, 3'b000, 1'b0);
    add_vec(8'hE0, 8'h04, 8'h00, 3'b000, 1'b0);
    add_vec(8'h75, 8'h04, 8'h08, 3'b000, 1'b0);
    add_vec(8'h1C, 8'h14, 8'h0A, 3'b000, 1'b0);
    add_vec(8'h1C, 8'h14, 8'h0A, 3'b000, 1'b0);
    add_vec(8'hE0, 8'h04, 8'h08, 3'b000, 1'b0);
    add_vec(8'hF0, 8'h04, 8'h08, 3'b000, 1'b0);
    add_vec(8'h75, 8'h04, 8'h00, 3'b000, 1'b0);
    add_vec(8'h12, 8'h00, 8'h00, 3'b001, 1'b0);
    add_vec(8'h16, 8'hFF, 8'h02, 3'b001, 1'b0);
    add_vec(8'h1E, 8'h10, 8'h02, 3'b001, 1'b0);
    add_vec(8'h14, 8'h10, 8'h02, 3'b011, 1'b0);
    add_vec(8'hF0, 8'h10, 8'h02, 3'b011, 1'b0);
    add_vec(8'h14, 8'h10, 8'h02, 3'b001, 1'b0);
    add_vec(8'h76, 8'h10, 8'h02, 3'b001, 1'b1);
    add_vec(8'hE1, 8'hC0, 8'h00, 3'b001, 1'b1);
    add_vec(8'h14, 8'hC0, 8'h00, 3'b001, 1'b1);
    add_vec(8'h77, 8'hC0, 8'h00, 3'b001, 1'b1);
    add_vec(8'hE1, 8'hC0, 8'h00, 3'b001, 1'b1);
    add_vec(8'hF0, 8'hC0, 8'h00, 3'b001, 1'b1);
    add_vec(8'h14, 8'hC0, 8'h00, 3'b001, 1'b1);
    add_vec(8'hF0, 8'hC0, 8'h00, 3'b001, 1'b1);
    add_vec(8'h77, 8'hC0, 8'h00, 3'b001, 1'b1);
    add_vec(8'h15, 8'h11, 8'h03, 3'b001, 1'b1);
    add_vec(8'hF0, 8'h11, 8'h03, 3'b001, 1'b1);
    add_vec(8'h76, 8'h11, 8'h03, 3'b001, 1'b0);
    add_vec(8'hF0, 8'h04, 8'h00, 3'b001, 1'b0);
    add_vec(8'hE0, 8'h04, 8'h00, 3'b001, 1'b0);
    add_vec(8'h75, 8'h04, 8'h08, 3'b001, 1'b0);
    add_vec(8'hAA, 8'hFF, 8'h00, 3'b000, 1'b0);
    add_vec(8'h1D, 8'h08, 8'h20, 3'b000, 1'b0);
    add_vec(8'h15, 8'h09, 8'h21, 3'b000, 1'b0);
    add_vec(8'h15, 8'h00, 8'h00, 3'b000, 1'b0);
    add_vec(8'h12, 8'hFF, 8'h21, 3'b001, 1'b0);
    add_vec(8'hFF, 8'hFF, 8'h00, 3'b000, 1'b0);
    add_vec(8'h1C, 8'h10, 8'h02, 3'b000, 1'b0);
    add_vec(8'h00, 8'hFF, 8'h00, 3'b000, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].code);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].addr, vecs[i].odata,
                  vecs[i].shift, vecs[i].krst);
    end

    // Key state must not move until the second edge after the strobe.
    addr = 8'h10;
    applyStimulus(8'h1C);
    checkOutput("latency_n1", 8'h10, 8'h00, 3'b000, 1'b0);
    tick();
    checkOutput("latency_n2", 8'h10, 8'h02, 3'b000, 1'b0);

    applyStimulus(8'h15);
    applyStimulus(8'h1D);
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    applyStimulus(8'h12);
    tick();
    checkOutput("back_to_back", 8'hFF, 8'h2B, 3'b001, 1'b0);

    applyStimulus(8'hF0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("reset_clears", 8'hFF, 8'h00, 3'b000, 1'b0);
    applyStimulus(8'h1C);
    tick();
    checkOutput("reset_mid_prefix", 8'hFF, 8'h02, 3'b000, 1'b0);

    applyStimulus(8'h15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    checkOutput("reset_discard", 8'hFF, 8'h00, 3'b000, 1'b0);

    code_valid = 1'b1;
    code       = 8'h1C;
    map_we     = 1'b1;
    map_addr   = 9'h01C;
    map_wdata  = entry(2'b01, 4'd5, 3'd0);
    tick();
    code_valid = 1'b0;
    map_we     = 1'b0;
    tick();
    checkOutput("read_first_old", 8'h30, 8'h02, 3'b000, 1'b0);
    applyStimulus(8'h1C);
    tick();
    checkOutput("write_landed", 8'h30, 8'h03, 3'b000, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
